// File: rtl/usb_tx_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package  : usb_tx_pkg                                                      |
// | Purpose  : Shared types and constants for the USB transmit scheduler.      |
// |            Provides the scheduler state type, the source-select encodings, |
// |            the default maximum packet length, and a length check helper.   |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
package usb_tx_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    STREAM = 2'd2
  } sched_state_t;

  localparam logic SRC_ND   = 1'b0;
  localparam logic SRC_DATA = 1'b1;

  localparam int MAX_LEN_DEFAULT = 64;

  // A length byte is legal when it is non-zero and no larger than max_len.
  function automatic logic len_legal(input logic [7:0] len, input logic [7:0] max_len);
    return (len != 8'd0) && (len <= max_len);
  endfunction

endpackage
`default_nettype wire

// File: rtl/nd_tx_mux.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : nd_tx_mux                                                       |
// | Purpose  : Combinational 2:1 source select for the TX scheduler. Presents  |
// |            the selected FIFO's head byte / empty flag and steers the pop   |
// |            strobe to the selected FIFO only.                               |
// | Ports    : src        - selected source (SRC_ND / SRC_DATA)                |
// |            nd_*, d_*  - FIFO head byte and empty flag of each source       |
// |            pop        - request to pop the selected FIFO                   |
// |            sel_data   - head byte of the selected FIFO                     |
// |            sel_empty  - empty flag of the selected FIFO                    |
// |            nd_r_enable, d_r_enable - per-FIFO pop strobes                  |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module nd_tx_mux
  import usb_tx_pkg::*;
(
  input  logic       src,
  input  logic [7:0] nd_r_data,
  input  logic       nd_empty,
  input  logic [7:0] d_r_data,
  input  logic       d_empty,
  input  logic       pop,
  output logic [7:0] sel_data,
  output logic       sel_empty,
  output logic       nd_r_enable,
  output logic       d_r_enable
);

  always_comb begin
    sel_data    = (src == SRC_DATA) ? d_r_data : nd_r_data;
    sel_empty   = (src == SRC_DATA) ? d_empty  : nd_empty;
    // Empty gating makes a pop of an empty FIFO impossible regardless of caller.
    nd_r_enable = pop && (src == SRC_ND)   && !nd_empty;
    d_r_enable  = pop && (src == SRC_DATA) && !d_empty;
  end

endmodule
`default_nettype wire

// File: rtl/nd_tx_sched.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : nd_tx_sched                                                     |
// | Purpose  : Packet-atomic scheduler sharing the USB TX byte path between    |
// |            the non-data FIFO and the encrypted-data FIFO. Packets are a    |
// |            length byte N followed by N payload bytes. Non-data has         |
// |            priority; a starvation counter forces a data packet after       |
// |            STARVE_LIMIT consecutive non-data packets while data waits.     |
// | Ports    : clk, n_rst           - clock, async active-low reset            |
// |            nd_r_data/nd_empty   - non-data FIFO head (FWFT) / empty        |
// |            nd_r_enable          - pop non-data FIFO                        |
// |            d_r_data/d_empty     - data FIFO head (FWFT) / empty            |
// |            d_r_enable           - pop data FIFO                            |
// |            tx_ready/tx_valid    - TX encoder handshake                     |
// |            tx_data/tx_last      - payload byte / final byte of packet      |
// |            tx_src               - source of current packet (0 nd, 1 data)  |
// |            frame_err            - one-cycle pulse on illegal length byte   |
// |            busy                 - scheduler not idle                       |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module nd_tx_sched
  import usb_tx_pkg::*;
#(
  parameter int MAX_LEN      = MAX_LEN_DEFAULT,
  parameter int STARVE_LIMIT = 4,
  parameter int CNT_W        = 7
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic [7:0] nd_r_data,
  input  logic       nd_empty,
  output logic       nd_r_enable,
  input  logic [7:0] d_r_data,
  input  logic       d_empty,
  output logic       d_r_enable,
  input  logic       tx_ready,
  output logic       tx_valid,
  output logic [7:0] tx_data,
  output logic       tx_last,
  output logic       tx_src,
  output logic       frame_err,
  output logic       busy
);

  localparam int         ST_W      = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam logic [7:0] MAX_LEN_B = 8'(MAX_LEN);

  sched_state_t     state;
  logic [CNT_W-1:0] count;
  logic [ST_W-1:0]  starve;

  logic [7:0] sel_data;
  logic       sel_empty;
  logic       pop;
  logic       xfer;
  logic       grant_data;

  nd_tx_mux u_mux (
    .src         (tx_src),
    .nd_r_data   (nd_r_data),
    .nd_empty    (nd_empty),
    .d_r_data    (d_r_data),
    .d_empty     (d_empty),
    .pop         (pop),
    .sel_data    (sel_data),
    .sel_empty   (sel_empty),
    .nd_r_enable (nd_r_enable),
    .d_r_enable  (d_r_enable)
  );

  always_comb begin
    tx_valid   = (state == STREAM) && !sel_empty;
    tx_data    = (state == STREAM) ? sel_data : 8'h00;
    tx_last    = tx_valid && (count == CNT_W'(1));
    xfer       = tx_valid && tx_ready;
    // LOAD consumes the length byte; STREAM pops only on an accepted transfer.
    pop        = (state == LOAD) || xfer;
    busy       = (state != IDLE);
    grant_data = !d_empty && (nd_empty || (starve == ST_W'(STARVE_LIMIT)));
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state     <= IDLE;
      count     <= '0;
      starve    <= '0;
      tx_src    <= SRC_ND;
      frame_err <= 1'b0;
    end else begin
      frame_err <= 1'b0;
      case (state)
        IDLE: begin
          if (!nd_empty || !d_empty) begin
            tx_src <= grant_data ? SRC_DATA : SRC_ND;
            state  <= LOAD;
          end
        end
        LOAD: begin
          count <= CNT_W'(sel_data);
          if (len_legal(sel_data, MAX_LEN_B)) begin
            state <= STREAM;
          end else begin
            frame_err <= 1'b1;
            state     <= IDLE;
          end
        end
        STREAM: begin
          if (xfer) begin
            count <= count - CNT_W'(1);
            if (count == CNT_W'(1)) begin
              state <= IDLE;
              // Only a non-data packet finishing while data waits builds pressure.
              if (tx_src == SRC_ND && !d_empty) begin
                if (starve != ST_W'(STARVE_LIMIT)) starve <= starve + ST_W'(1);
              end else begin
                starve <= '0;
              end
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire
